shr_pattern_driver: RTL and testbench
=====================================

# shr_pattern_driver

Serializes the 1024-bit control pattern delivered by the virtual-JTAG buffer stage into the external shift-register chain on the DE0 header (serial data, shift clock, latch). Sits directly downstream of the JTAG buffer: its parallel pattern output feeds `pattern_in`, and its update-DR strobe feeds `update`. Runs on the board system clock. Synchronizes the JTAG-domain strobe, and shifts one frame per accepted update, then pulses latch so all register outputs change together.

## Interface
- `WIDTH`, 1024: pattern length in bits, ≥2.
- `DIV`, 25: clk cycles per half-period of `shr_clk`, ≥1.
- `clk` in 1: system clock.
- `aclr_n` in 1: asynchronous active-low reset.
- `pattern_in` in WIDTH: parallel pattern. Quasi-static; sampled only in LOAD.
- `update` in 1: JTAG-domain update strobe, asynchronous to `clk`. Only a rising edge matters.
- `shr_data` out 1: serial data, MSB (`pattern_in[WIDTH-1]`) first.
- `shr_clk` out 1: shift clock. The external register samples on its rising edge.
- `shr_latch` out 1: storage-register latch, active high.
- `busy` out 1: high from LOAD through LATCH inclusive.
- `done` out 1: one-cycle pulse at frame completion.
- `frame_cnt` out 16: completed-frame counter. Wraps 0xFFFF→0.

## Operation
- Reset (async, `aclr_n`=0): state=IDLE. `shr_data`, `shr_clk`, `shr_latch`, `busy`, `done` = 0. `frame_cnt`=0. Sync flops, pending flag, shadow register, bit and divider counters = 0.
- `update` passes a 3-flop chain: sync1, sync2, then a delay flop. `start` = sync2 & ~delay, a one-cycle pulse per rising edge. A level held high yields a single start.
- `pending` flag: set by `start`, cleared on entry to LOAD. If `start` and the LOAD entry coincide, `pending` is cleared (the start is consumed). A `start` during `busy` sets `pending`. Any number of starts during one frame collapse to one extra frame.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE: if `pending` (or `start` this cycle), go to LOAD next cycle.
  - LOAD (1 cycle): shadow←`pattern_in`; bit_cnt←WIDTH-1; div_cnt←0; → SHIFT_LO.
  - SHIFT_LO (DIV cycles): `shr_clk`=0; `shr_data`=shadow[WIDTH-1]; → SHIFT_HI when div_cnt=DIV-1.
  - SHIFT_HI (DIV cycles): `shr_clk`=1; `shr_data` held. At div_cnt=DIV-1:
    - if bit_cnt=0 → LATCH;
    - else shadow←shadow<<1, bit_cnt−1, → SHIFT_LO.
  - LATCH (DIV cycles): `shr_clk`=0; `shr_latch`=1. On exit: `done`=1 for one cycle, `frame_cnt`+1, → IDLE. If `pending` is set, the next cycle enters LOAD.
- div_cnt resets to 0 on every state change.
- `shr_data` changes only on the SHIFT_HI→SHIFT_LO transition or on LOAD→SHIFT_LO. It never changes while `shr_clk`=1 (setup/hold = DIV cycles each).
- `pattern_in` changes after LOAD do not affect the frame in flight.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- `update` rising edge → `start`: 3 clk cycles worst case (2 sync + edge register).
- `start` → LOAD: 1 cycle when IDLE.
- Frame length, counted from the LOAD cycle through the last LATCH cycle: 1 + 2·DIV·WIDTH + DIV cycles. Defaults: 1 + 51200 + 25 = 51226 cycles (~1.02 ms at 50 MHz).
- `done` asserts in the cycle after the last LATCH cycle, concurrent with IDLE. `busy` is 0 that cycle.
- Back-to-back frames: at least 1 IDLE cycle between the end of LATCH and the next LOAD.
- Reset mid-frame: outputs drop to reset values immediately. Partial frame is abandoned; no `done`; `frame_cnt` unchanged by the partial frame (it is reset to 0 anyway). Pending request is discarded.

## Test plan
- WIDTH=8, DIV=2, `pattern_in`=8'hA5, one `update` pulse → `shr_data` sampled at each `shr_clk` rise = 1,0,1,0,0,1,0,1. `shr_latch` high for 2 cycles. `busy` high for 35 cycles. `done` pulses once. `frame_cnt`=1.
- Same config, `update` held high for 100 cycles → exactly one frame, `frame_cnt`=1.
- `update` pulsed 3 times during a frame with `pattern_in` changed to 8'h3C after LOAD → first frame shifts A5. Exactly one more frame shifts 3C. `frame_cnt`=2.
- `aclr_n` low during bit 4 of a frame → all outputs 0 asynchronously. No `done`. After release, an `update` produces a clean full frame.
- WIDTH=2, DIV=1, pattern 2'b10 → `shr_clk` toggles every cycle, data 1 then 0. `busy` is 6 cycles long. Latch is 1 cycle.
- Preload `frame_cnt` path by running 65536 frames (WIDTH=2, DIV=1) → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/shr_pattern_driver.sv
// Shifts a WIDTH-bit pattern MSB-first into an external shift-register chain,
// then latches it. Ports:
//   clk, aclr_n      : system clock, async active-low reset
//   pattern_in       : parallel pattern, captured once per frame in LOAD
//   update           : async strobe, each rising edge requests one frame
//   shr_data/clk     : serial data and shift clock (external samples on rise)
//   shr_latch        : storage-register latch, active high
//   busy, done       : frame in progress / one-cycle completion pulse
//   frame_cnt        : completed-frame counter, wraps
module shr_pattern_driver #(
    parameter int WIDTH = 1024,
    parameter int DIV   = 25
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             update,
    output logic             shr_data,
    output logic             shr_clk,
    output logic             shr_latch,
    output logic             busy,
    output logic             done,
    output logic [15:0]      frame_cnt
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, dly_q;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             done_q, done_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             clk_q, latch_q, busy_q;
    logic             start;
    logic             div_end;

    // Third flop only detects the rising edge of the synchronized strobe.
    assign start   = sync2_q & ~dly_q;
    assign div_end = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | start;
        shadow_d  = shadow_q;
        bit_d     = bit_q;
        div_d     = div_q + 1'b1;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (pending_q || start) begin
                    state_d   = LOAD;
                    // A start coinciding with LOAD entry is consumed here.
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                shadow_d = pattern_in;
                bit_d    = BIT_LAST;
                div_d    = '0;
                state_d  = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == '0) begin
                        state_d = LATCH;
                    end else begin
                        // Data moves only as shr_clk falls.
                        shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
                        bit_d    = bit_q - 1'b1;
                        state_d  = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dly_q     <= 1'b0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= update;
            sync2_q   <= sync1_q;
            dly_q     <= sync2_q;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            // Decoded from next state so they line up with state_q.
            clk_q     <= (state_d == SHIFT_HI);
            latch_q   <= (state_d == LATCH);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign shr_data  = shadow_q[WIDTH-1];
    assign shr_clk   = clk_q;
    assign shr_latch = latch_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_shr_pattern_driver.sv
// Bench for shr_pattern_driver: 8-bit/DIV=2 and 2-bit/DIV=1 instances,
// table-driven frames plus hand sequences for multi-cycle corner cases.
module tb_shr_pattern_driver;

    logic        clk;
    logic        aclr_n;
    logic [7:0]  pat_a;
    logic        upd_a;
    logic        a_data, a_clk, a_latch, a_busy, a_done;
    logic [15:0] a_cnt;
    logic [1:0]  pat_b;
    logic        upd_b;
    logic        b_data, b_clk, b_latch, b_busy, b_done;
    logic [15:0] b_cnt;

    shr_pattern_driver #(.WIDTH(8), .DIV(2)) dut_a (
        .clk(clk), .aclr_n(aclr_n), .pattern_in(pat_a), .update(upd_a),
        .shr_data(a_data), .shr_clk(a_clk), .shr_latch(a_latch),
        .busy(a_busy), .done(a_done), .frame_cnt(a_cnt)
    );

    shr_pattern_driver #(.WIDTH(2), .DIV(1)) dut_b (
        .clk(clk), .aclr_n(aclr_n), .pattern_in(pat_b), .update(upd_b),
        .shr_data(b_data), .shr_clk(b_clk), .shr_latch(b_latch),
        .busy(b_busy), .done(b_done), .frame_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] ma_cap;
    logic [7:0] ma_frames [4];
    int ma_bits, ma_busy, ma_latch, ma_done, ma_hichg, ma_gap;
    logic ma_pclk, ma_pdata;
    logic [1:0] mb_cap;
    int mb_bits, mb_busy, mb_latch, mb_done, mb_hi;
    logic mb_pclk;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] bits;
        int         busy;
        int         latch;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_a;
        ma_cap = '0; ma_bits = 0; ma_busy = 0; ma_latch = 0;
        ma_done = 0; ma_hichg = 0; ma_gap = 0;
        for (int i = 0; i < 4; i++) ma_frames[i] = '0;
    endtask

    task automatic clear_b;
        mb_cap = '0; mb_bits = 0; mb_busy = 0; mb_latch = 0;
        mb_done = 0; mb_hi = 0;
    endtask

    task automatic mon_cycle;
        @(negedge clk);
        if (a_clk && !ma_pclk) begin
            ma_cap = {ma_cap[6:0], a_data};
            ma_bits++;
        end
        if (a_clk && ma_pclk && a_data != ma_pdata) ma_hichg++;
        if (a_done) begin
            if (ma_done < 4) ma_frames[ma_done] = ma_cap;
            ma_done++;
        end
        if (ma_done == 1 && !a_busy) ma_gap++;
        if (a_busy) ma_busy++;
        if (a_latch) ma_latch++;
        ma_pclk = a_clk;
        ma_pdata = a_data;
        if (b_clk && !mb_pclk) begin
            mb_cap = {mb_cap[0], b_data};
            mb_bits++;
        end
        if (b_clk) mb_hi++;
        if (b_done) mb_done++;
        if (b_busy) mb_busy++;
        if (b_latch) mb_latch++;
        mb_pclk = b_clk;
    endtask

    task automatic pulse_a;
        upd_a = 1'b1;
        repeat (2) mon_cycle();
        upd_a = 1'b0;
        repeat (3) mon_cycle();
    endtask

    task automatic pulse_b;
        upd_b = 1'b1;
        repeat (2) mon_cycle();
        upd_b = 1'b0;
        repeat (3) mon_cycle();
    endtask

    task automatic wait_a(input int target, input int budget,
                          input string nm);
        int n;
        n = 0;
        while (ma_done < target && n < budget) begin
            mon_cycle();
            n++;
        end
        check(nm, 32'(ma_done >= target), 32'd1);
    endtask

    initial begin
        vt[0] = '{pat: 8'hA5, bits: 8'hA5, busy: 35, latch: 2};
        vt[1] = '{pat: 8'h3C, bits: 8'h3C, busy: 35, latch: 2};
        vt[2] = '{pat: 8'hFF, bits: 8'hFF, busy: 35, latch: 2};
        vt[3] = '{pat: 8'h00, bits: 8'h00, busy: 35, latch: 2};
        vt[4] = '{pat: 8'h81, bits: 8'h81, busy: 35, latch: 2};

        aclr_n = 1'b0;
        upd_a = 1'b0;
        upd_b = 1'b0;
        pat_a = 8'h00;
        pat_b = 2'b00;
        ma_pclk = 1'b0;
        ma_pdata = 1'b0;
        mb_pclk = 1'b0;
        clear_a();
        clear_b();
        repeat (3) mon_cycle();
        check("rst_a_outs", 32'({a_data, a_clk, a_latch, a_busy, a_done}), 0);
        check("rst_a_cnt", 32'(a_cnt), 0);
        check("rst_b_outs", 32'({b_data, b_clk, b_latch, b_busy, b_done}), 0);
        aclr_n = 1'b1;
        repeat (3) mon_cycle();

        for (int i = 0; i < 5; i++) begin
            clear_a();
            pat_a = vt[i].pat;
            pulse_a();
            wait_a(1, 80, "t1_done_seen");
            repeat (5) mon_cycle();
            check("t1_bits", 32'(ma_cap), 32'(vt[i].bits));
            check("t1_nbits", 32'(ma_bits), 8);
            check("t1_busy", 32'(ma_busy), 32'(vt[i].busy));
            check("t1_latch", 32'(ma_latch), 32'(vt[i].latch));
            check("t1_done_once", 32'(ma_done), 1);
            check("t1_hold_hi", 32'(ma_hichg), 0);
            check("t1_cnt", 32'(a_cnt), 32'(i + 1));
        end

        clear_a();
        pat_a = 8'h5A;
        upd_a = 1'b1;
        repeat (100) mon_cycle();
        upd_a = 1'b0;
        repeat (20) mon_cycle();
        check("t2_frames", 32'(ma_done), 1);
        check("t2_bits", 32'(ma_frames[0]), 32'h5A);
        check("t2_cnt", 32'(a_cnt), 6);

        clear_a();
        pat_a = 8'hA5;
        pulse_a();
        for (int n = 0; n < 40 && ma_bits < 1; n++) mon_cycle();
        check("t3_started", 32'(ma_bits >= 1), 1);
        pat_a = 8'h3C;
        repeat (3) pulse_a();
        wait_a(2, 150, "t3_second_done");
        repeat (60) mon_cycle();
        check("t3_frame0", 32'(ma_frames[0]), 32'hA5);
        check("t3_frame1", 32'(ma_frames[1]), 32'h3C);
        check("t3_nframes", 32'(ma_done), 2);
        check("t3_idle_gap", 32'(ma_gap), 1);
        check("t3_busy", 32'(ma_busy), 70);
        check("t3_cnt", 32'(a_cnt), 8);

        clear_a();
        pat_a = 8'hC3;
        pulse_a();
        for (int n = 0; n < 60 && ma_bits < 4; n++) mon_cycle();
        check("t4_mid", 32'(ma_bits), 4);
        aclr_n = 1'b0;
        #1;
        check("t4_async_outs", 32'({a_data, a_clk, a_latch, a_busy, a_done}), 0);
        check("t4_async_cnt", 32'(a_cnt), 0);
        clear_a();
        repeat (3) mon_cycle();
        aclr_n = 1'b1;
        repeat (20) mon_cycle();
        check("t4_no_done", 32'(ma_done), 0);
        check("t4_idle", 32'(ma_busy), 0);
        clear_a();
        pulse_a();
        wait_a(1, 80, "t4_done_seen");
        repeat (5) mon_cycle();
        check("t4_bits", 32'(ma_cap), 32'hC3);
        check("t4_busy", 32'(ma_busy), 35);
        check("t4_cnt", 32'(a_cnt), 1);

        clear_b();
        pat_b = 2'b10;
        pulse_b();
        for (int n = 0; n < 30 && mb_done < 1; n++) mon_cycle();
        repeat (3) mon_cycle();
        check("t5_bits", 32'(mb_cap), 32'h2);
        check("t5_nbits", 32'(mb_bits), 2);
        check("t5_clk_hi", 32'(mb_hi), 2);
        check("t5_busy", 32'(mb_busy), 6);
        check("t5_latch", 32'(mb_latch), 1);
        check("t5_done", 32'(mb_done), 1);
        check("t5_cnt", 32'(b_cnt), 1);
        for (int k = 0; k < 3; k++) begin
            pulse_b();
            repeat (8) mon_cycle();
        end
        check("t5_cnt3", 32'(b_cnt), 4);
        check("t5_done3", 32'(mb_done), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
